// File: rtl/muldiv_seq_pkg.sv
// Shared constants, state encoding and operand helpers for the iterative RV32M unit.
package muldiv_seq_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ITER       = 32;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned ACC_W      = 2 * XLEN;
  localparam int unsigned MD_LATENCY = 34;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_MD_IDLE = 2'd0,
    ST_MD_CALC = 2'd1,
    ST_MD_FIX  = 2'd2,
    ST_MD_DONE = 2'd3
  } mdState_t;

  function automatic logic aSigned(input logic [2:0] funct3);
    return (funct3 == FUNCT3_MULH) || (funct3 == FUNCT3_MULHSU) ||
           (funct3 == FUNCT3_DIV)  || (funct3 == FUNCT3_REM);
  endfunction

  function automatic logic bSigned(input logic [2:0] funct3);
    return (funct3 == FUNCT3_MULH) || (funct3 == FUNCT3_DIV) || (funct3 == FUNCT3_REM);
  endfunction

  // Magnitude of a two's complement value; 0x80000000 maps to itself as unsigned.
  function automatic logic [XLEN-1:0] absVal(input logic [XLEN-1:0] v, input logic neg);
    return neg ? XLEN'(-v) : v;
  endfunction

endpackage

// File: rtl/muldiv_seq_step.sv
// One iteration of the engine: shift-add multiply or restoring shift-subtract divide.
module muldiv_step
  import muldiv_seq_pkg::*;
(
  input  logic             iDiv,
  input  logic [ACC_W-1:0] iAcc,
  input  logic [XLEN-1:0]  iOperand,
  output logic [ACC_W-1:0] oAcc
);

  logic [XLEN:0]   sum;
  logic [XLEN+1:0] diff;

  always_comb begin
    sum  = '0;
    diff = '0;
    oAcc = iAcc;
    if (!iDiv) begin
      sum  = {1'b0, iAcc[ACC_W-1:XLEN]} + (iAcc[0] ? {1'b0, iOperand} : (XLEN+1)'(0));
      oAcc = {sum, iAcc[XLEN-1:1]};
    end else begin
      // Partial remainder shifted left by one is {acc[63:31]}, 33 bits wide.
      diff = {1'b0, iAcc[ACC_W-1:XLEN-1]} - {2'b00, iOperand};
      if (!diff[XLEN+1]) begin
        oAcc = {diff[XLEN-1:0], iAcc[XLEN-2:0], 1'b1};
      end else begin
        oAcc = {iAcc[ACC_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit, fixed 34-cycle latency.
// Define MULDIV_SHORTCUT_EN to let div-by-zero and signed-overflow divides skip CALC.
module muldiv_seq
  import muldiv_seq_pkg::*;
(
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iStart,
  input  logic [2:0]      iFunct3,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  output logic            oBusy,
  output logic            oDone,
  output logic [XLEN-1:0] oResult
);

  mdState_t         state;
  logic [2:0]       funct3Q;
  logic [XLEN-1:0]  aQ;
  logic [XLEN-1:0]  bQ;
  logic [XLEN-1:0]  opMag;
  logic             negA;
  logic             negB;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] accNext;
  logic [CNT_W-1:0] cnt;

  logic             startNegA;
  logic             startNegB;
  logic [XLEN-1:0]  startMagA;
  logic [XLEN-1:0]  startMagB;

  logic [ACC_W-1:0] prodS;
  logic [XLEN-1:0]  quoS;
  logic [XLEN-1:0]  remS;
  logic             divZero;
  logic             divOvf;
  logic [XLEN-1:0]  fixResult;

  assign startNegA = aSigned(iFunct3) & iA[XLEN-1];
  assign startNegB = bSigned(iFunct3) & iB[XLEN-1];
  assign startMagA = absVal(iA, startNegA);
  assign startMagB = absVal(iB, startNegB);

`ifdef MULDIV_SHORTCUT_EN
  logic startSpecial;
  assign startSpecial = iFunct3[2] &&
                        ((iB == '0) ||
                         (!iFunct3[0] && (iA == 32'h8000_0000) && (iB == 32'hFFFF_FFFF)));
`endif

  muldiv_step uStep (
    .iDiv    (funct3Q[2]),
    .iAcc    (acc),
    .iOperand(opMag),
    .oAcc    (accNext)
  );

  // Sign correction, word select and special-case override for the FIX cycle.
  always_comb begin
    prodS   = (negA ^ negB) ? ACC_W'(-acc) : acc;
    quoS    = (negA ^ negB) ? XLEN'(-acc[XLEN-1:0]) : acc[XLEN-1:0];
    remS    = negA ? XLEN'(-acc[ACC_W-1:XLEN]) : acc[ACC_W-1:XLEN];
    divZero = (bQ == '0);
    divOvf  = !funct3Q[0] && (aQ == 32'h8000_0000) && (bQ == 32'hFFFF_FFFF);
    fixResult = '0;
    case (funct3Q)
      FUNCT3_MUL:    fixResult = prodS[XLEN-1:0];
      FUNCT3_MULH,
      FUNCT3_MULHSU,
      FUNCT3_MULHU:  fixResult = prodS[ACC_W-1:XLEN];
      FUNCT3_DIV:    fixResult = divZero ? '1 : (divOvf ? 32'h8000_0000 : quoS);
      FUNCT3_DIVU:   fixResult = divZero ? '1 : quoS;
      FUNCT3_REM:    fixResult = divZero ? aQ : (divOvf ? '0 : remS);
      default:       fixResult = divZero ? aQ : remS;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state   <= ST_MD_IDLE;
      funct3Q <= '0;
      aQ      <= '0;
      bQ      <= '0;
      opMag   <= '0;
      negA    <= 1'b0;
      negB    <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
      oResult <= '0;
    end else begin
      oDone <= 1'b0;
      case (state)
        ST_MD_IDLE: begin
          if (iStart) begin
            funct3Q <= iFunct3;
            aQ      <= iA;
            bQ      <= iB;
            negA    <= startNegA;
            negB    <= startNegB;
            cnt     <= '0;
            oBusy   <= 1'b1;
            // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
            if (iFunct3[2]) begin
              acc   <= {{XLEN{1'b0}}, startMagA};
              opMag <= startMagB;
            end else begin
              acc   <= {{XLEN{1'b0}}, startMagB};
              opMag <= startMagA;
            end
`ifdef MULDIV_SHORTCUT_EN
            state <= startSpecial ? ST_MD_FIX : ST_MD_CALC;
`else
            state <= ST_MD_CALC;
`endif
          end
        end
        ST_MD_CALC: begin
          acc <= accNext;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(ITER - 1)) begin
            state <= ST_MD_FIX;
          end
        end
        ST_MD_FIX: begin
          oResult <= fixResult;
          oBusy   <= 1'b0;
          state   <= ST_MD_DONE;
        end
        ST_MD_DONE: begin
          oDone <= 1'b1;
          state <= ST_MD_IDLE;
        end
        default: state <= ST_MD_IDLE;
      endcase
    end
  end

endmodule
